// File: rtl/core_tick_gen.sv
// Core clock-enable generator with run / halt / single-step / N-tick burst modes.
// Optional 32-bit tick counter is built only when CORE_TICK_COUNT_EN is defined.
module core_tick_gen #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned CORE_FREQ = 1000000,
  parameter int unsigned BURST_W   = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         mode_i,
  input  logic               start_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               tick_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [31:0]        tick_count_o
);

  localparam int unsigned DIV_RAW = CLK_FREQ / ((CORE_FREQ == 0) ? 1 : CORE_FREQ);
  localparam int unsigned DIV     = (CORE_FREQ == 0 || DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_HALT  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_BURST
  } state_t;

  state_t             r_state;
  logic [PW-1:0]      r_presc;
  logic [BURST_W-1:0] r_remaining;
  logic               r_tick;
  logic               r_busy;
  logic               r_done;

  logic               w_wrap;
  logic [PW-1:0]      w_presc_next;
  logic [BURST_W-1:0] w_len_eff;
  logic [BURST_W-1:0] w_rem_load;
  logic               w_start_burst;
  logic               w_empty_burst;

  // The edge leaving IDLE already counts as the first prescaler step, so the
  // first tick lands exactly DIV cycles after the request was sampled.
  assign w_wrap        = (r_presc == PW'(DIV - 1));
  assign w_presc_next  = w_wrap ? '0 : r_presc + PW'(1);
  assign w_len_eff     = (mode_i == MODE_STEP) ? BURST_W'(1) : burst_len_i;
  assign w_rem_load    = w_len_eff - (w_wrap ? BURST_W'(1) : '0);
  assign w_start_burst = start_i && ((mode_i == MODE_STEP) ||
                                     ((mode_i == MODE_BURST) && (burst_len_i != '0)));
  assign w_empty_burst = start_i && (mode_i == MODE_BURST) && (burst_len_i == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_remaining <= '0;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy  <= 1'b0;
          r_presc <= '0;
          if (mode_i == MODE_RUN) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_presc <= w_presc_next;
            r_tick  <= w_wrap;
          end else if (w_start_burst) begin
            r_state     <= S_BURST;
            r_busy      <= 1'b1;
            r_presc     <= w_presc_next;
            r_tick      <= w_wrap;
            r_remaining <= w_rem_load;
          end else if (w_empty_burst) begin
            r_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (mode_i != MODE_RUN) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_presc <= '0;
          end else begin
            r_presc <= w_presc_next;
            r_tick  <= w_wrap;
          end
        end
        S_BURST: begin
          if (mode_i == MODE_HALT) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_presc     <= '0;
            r_remaining <= '0;
          end else if (r_remaining == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_presc <= '0;
          end else begin
            r_presc <= w_presc_next;
            if (w_wrap) begin
              r_tick      <= 1'b1;
              r_remaining <= r_remaining - BURST_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_presc <= '0;
        end
      endcase
    end
  end

  assign tick_o = r_tick;
  assign busy_o = r_busy;
  assign done_o = r_done;

`ifdef CORE_TICK_COUNT_EN
  logic [31:0] r_tick_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_tick_count <= '0;
    end else if (r_tick) begin
      r_tick_count <= r_tick_count + 32'd1;
    end
  end

  assign tick_count_o = r_tick_count;
`else
  assign tick_count_o = '0;
`endif

endmodule

// File: tb/tb_core_tick_gen.sv
// Bench for core_tick_gen: DIV=10 instance for mode sequencing, DIV=1 instance
// for the every-cycle tick case. Expected outputs come from closed-form timing rules.
module tb_core_tick_gen;

  localparam int D_A = 10;

  localparam logic [1:0] M_RUN   = 2'b00;
  localparam logic [1:0] M_HALT  = 2'b01;
  localparam logic [1:0] M_STEP  = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, rst_b, start_b;
  logic [1:0]  mode_a, mode_b;
  logic [15:0] len_a, len_b;
  logic        tick_a, busy_a, done_a, tick_b, busy_b, done_b;
  logic [31:0] cnt_a, cnt_b;

  int vectors     = 0;
  int miscompares = 0;
  int unsigned mc_a = 0;
  int unsigned mc_b = 0;

  core_tick_gen #(.CLK_FREQ(100), .CORE_FREQ(10), .BURST_W(16)) u_dut_a (
    .clk_i(clk), .reset_i(rst_a), .mode_i(mode_a), .start_i(start_a),
    .burst_len_i(len_a), .tick_o(tick_a), .busy_o(busy_a), .done_o(done_a),
    .tick_count_o(cnt_a)
  );

  core_tick_gen #(.CLK_FREQ(100), .CORE_FREQ(100), .BURST_W(16)) u_dut_b (
    .clk_i(clk), .reset_i(rst_b), .mode_i(mode_b), .start_i(start_b),
    .burst_len_i(len_b), .tick_o(tick_b), .busy_o(busy_b), .done_o(done_b),
    .tick_count_o(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned mc);
`ifdef CORE_TICK_COUNT_EN
    return mc;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int k, input bit et, input bit eb, input bit ed);
    chk($sformatf("%s tick k=%0d", tag, k), {31'b0, tick_a}, {31'b0, et});
    chk($sformatf("%s busy k=%0d", tag, k), {31'b0, busy_a}, {31'b0, eb});
    chk($sformatf("%s done k=%0d", tag, k), {31'b0, done_a}, {31'b0, ed});
    chk($sformatf("%s count k=%0d", tag, k), cnt_a, exp_cnt(mc_a));
    if (et) mc_a++;
  endtask

  task automatic check_b(input string tag, input int k, input bit et, input bit eb, input bit ed);
    chk($sformatf("%s tick k=%0d", tag, k), {31'b0, tick_b}, {31'b0, et});
    chk($sformatf("%s busy k=%0d", tag, k), {31'b0, busy_b}, {31'b0, eb});
    chk($sformatf("%s done k=%0d", tag, k), {31'b0, done_b}, {31'b0, ed});
    chk($sformatf("%s count k=%0d", tag, k), cnt_b, exp_cnt(mc_b));
    if (et) mc_b++;
  endtask

  function automatic logic [1:0] rand_nonhalt();
    int unsigned r;
    r = $urandom_range(0, 2);
    return (r == 0) ? M_RUN : ((r == 1) ? M_STEP : M_BURST);
  endfunction

  // is_burst=0: mode run for cycles 0..arg-1, then halt.
  // is_burst=1: start of an n-tick burst at cycle 0; arg>0 means halt applied at cycle arg.
  task automatic scenario_a(input string tag, input bit is_burst, input int n,
                            input int arg, input bit use_step);
    int  tend, lim, k;
    bit  et, eb, ed, active;
    if (!is_burst)   tend = arg + 1;
    else if (n == 0) tend = 1;
    else if (arg > 0) tend = arg;
    else             tend = n * D_A + 1;
    lim = (arg > 0) ? arg : n * D_A;
    for (int c = 0; c <= tend + 3; c++) begin
      len_a = 16'($urandom_range(0, 65535));
      if (!is_burst) begin
        mode_a  = (c < arg) ? M_RUN : M_HALT;
        start_a = 1'($urandom_range(0, 1));
      end else if (c == 0) begin
        mode_a  = use_step ? M_STEP : M_BURST;
        start_a = 1'b1;
        if (!use_step) len_a = 16'(n);
      end else begin
        active = (n > 0) && ((arg > 0) ? (c < arg) : (c <= n * D_A));
        if (active) begin
          mode_a  = rand_nonhalt();
          start_a = (c == 5) ? 1'b1 : 1'($urandom_range(0, 1));
        end else begin
          mode_a  = M_HALT;
          start_a = 1'($urandom_range(0, 1));
        end
      end
      step_cycle();
      k = c + 1;
      if (!is_burst) begin
        et = (k % D_A == 0) && (k >= D_A) && (k <= arg);
        eb = (k <= arg);
        ed = 1'b0;
      end else begin
        et = (n > 0) && (k % D_A == 0) && (k / D_A >= 1) && (k / D_A <= n) && (k <= lim);
        eb = (n > 0) && (k <= lim);
        ed = ((n == 0) && (k == 1)) || ((n > 0) && (arg == 0) && (k == n * D_A + 1));
      end
      check_a(tag, k, et, eb, ed);
    end
  endtask

  initial begin
    int n, a, l, r;
    bit st;

    // Reset held for two cycles with arbitrary inputs.
    rst_b = 1'b1; mode_b = M_HALT; start_b = 1'b0; len_b = '0;
    for (int i = 0; i < 2; i++) begin
      rst_a   = 1'b1;
      mode_a  = 2'($urandom_range(0, 3));
      start_a = 1'($urandom_range(0, 1));
      len_a   = 16'($urandom_range(0, 65535));
      step_cycle();
      check_a("reset", i + 1, 1'b0, 1'b0, 1'b0);
      check_b("reset_b", i + 1, 1'b0, 1'b0, 1'b0);
    end
    rst_a = 1'b0; rst_b = 1'b0; mode_a = M_HALT; start_a = 1'b0;
    step_cycle();
    check_a("post_reset", 0, 1'b0, 1'b0, 1'b0);

    scenario_a("run35", 1'b0, 0, 35, 1'b0);
    scenario_a("step", 1'b1, 1, 0, 1'b1);
    scenario_a("burst3", 1'b1, 3, 0, 1'b0);
    scenario_a("burst0", 1'b1, 0, 0, 1'b0);
    scenario_a("abort5", 1'b1, 5, 15, 1'b0);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        l = int'($urandom_range(1, 40));
        scenario_a($sformatf("rnd_run%0d", it), 1'b0, 0, l, 1'b0);
      end else begin
        n  = int'($urandom_range(0, 4));
        a  = 0;
        if (n > 0 && $urandom_range(0, 1) == 1) a = int'($urandom_range(1, n * D_A - 1));
        st = (n == 1) && ($urandom_range(0, 1) == 1);
        scenario_a($sformatf("rnd_burst%0d", it), 1'b1, n, a, st);
      end
    end

    // Reset asserted in the middle of a run.
    r = int'($urandom_range(3, 25));
    for (int c = 0; c < r; c++) begin
      mode_a = M_RUN; start_a = 1'b0;
      step_cycle();
      check_a("run_pre_rst", c + 1, ((c + 1) % D_A == 0), 1'b1, 1'b0);
    end
    rst_a = 1'b1; mode_a = M_RUN;
    step_cycle();
    mc_a = 0;
    check_a("rst_in_run", 0, 1'b0, 1'b0, 1'b0);
    rst_a = 1'b0; mode_a = M_HALT;
    step_cycle();
    check_a("rst_in_run_idle", 0, 1'b0, 1'b0, 1'b0);
    scenario_a("run_after_rst", 1'b0, 0, 12, 1'b0);

    // DIV = 1: tick every cycle from cycle 1 while running.
    for (int c = 0; c < 24; c++) begin
      mode_b  = (c < 20) ? M_RUN : M_HALT;
      start_b = 1'($urandom_range(0, 1));
      len_b   = 16'($urandom_range(0, 65535));
      step_cycle();
      check_b("div1_run", c + 1, (c + 1 <= 20), (c + 1 <= 20), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_tick_gen.md
Name: core_tick_gen

Overview:
- Parametrised core clock-enable generator for the SoC top level.
- Derives a one-cycle core tick from the board clock using the CLK_FREQ / CORE_FREQ ratio.
- Adds debug execution modes the fixed-ratio top lacks: free-run, halt, single-step and N-tick burst, plus a tick counter visible on debug ports.
- Sits between the top-level clock/reset and the soc core-enable input.

Parameters:
- CLK_FREQ, 100000000, board clock frequency in Hz.
- CORE_FREQ, 1000000, target core tick rate in Hz.
- BURST_W, 16, width of the burst length input.

Ports:
- clk_i  input  1  board clock.
- reset_i  input  1  reset.
- mode_i  input  2  execution mode: 00 run, 01 halt, 10 step, 11 burst.
- start_i  input  1  one-cycle request to begin a step or burst.
- burst_len_i  input  BURST_W  number of ticks for a burst; sampled on an accepted start_i.
- tick_o  output  1  registered one-cycle core enable.
- busy_o  output  1  high while running, stepping or bursting.
- done_o  output  1  one-cycle pulse when a step or burst completes.
- tick_count_o  output  32  total ticks issued since reset.

Interface: one clock, clk_i; reset_i is synchronous and active-high.

Behaviour:
- DIV = CLK_FREQ / CORE_FREQ, truncating integer division. If CORE_FREQ is 0 or DIV < 1, DIV is forced to 1.
- Prescaler counter width is clog2(DIV), minimum 1 bit.
- Reset, sampled at a clock edge: state IDLE, prescaler 0, remaining 0. tick_o, busy_o, done_o and tick_count_o are all 0 after that edge.
- Reset has priority over every other input, including mid-run and mid-burst.
- States: IDLE, RUN, BURST. A step is a BURST with remaining = 1.
- IDLE:
  - prescaler held at 0; busy_o = 0.
  - mode_i = run: go to RUN.
  - start_i with mode step: go to BURST with remaining = 1.
  - start_i with mode burst and burst_len_i > 0: go to BURST with remaining = burst_len_i.
  - start_i with mode burst and burst_len_i = 0: stay IDLE; done_o pulses the next cycle; no tick.
  - start_i with mode run or halt: ignored.
- RUN:
  - busy_o = 1; prescaler increments every cycle.
  - When prescaler = DIV-1, tick_o is asserted the following cycle and the prescaler returns to 0.
  - The first tick occurs DIV cycles after the cycle in which mode_i = run is first sampled in IDLE. For DIV = 1, tick_o is high every cycle.
  - mode_i != run: return to IDLE, prescaler cleared, no further ticks. A tick already registered still appears.
  - start_i is ignored in RUN.
- BURST:
  - busy_o = 1; prescaler behaves as in RUN; each tick decrements remaining.
  - Timing relative to start_i at cycle 0: ticks occur at cycles DIV, 2*DIV, …, N*DIV.
  - done_o pulses at cycle N*DIV+1. busy_o is high for cycles 1..N*DIV and low in the done_o cycle.
  - mode_i = halt: abort. IDLE at the next edge, busy_o low, no done_o, no further ticks.
  - Any other mode change, or start_i, is ignored until completion.
- tick_o, busy_o and done_o are all registered.
- tick_count_o increments by 1 in the cycle after each tick_o pulse. It wraps from 0xFFFFFFFF to 0 and is cleared only by reset.

Optional Feature:
- Macro: CORE_TICK_COUNT_EN.
- Defined: 32-bit tick counter implemented as described above.
- Undefined: no counter register is built; tick_count_o is tied to 0; all other behaviour is unchanged.

Test Plan (CLK_FREQ=100, CORE_FREQ=10, so DIV=10, unless stated; CORE_TICK_COUNT_EN defined):
- Reset: hold reset_i for 2 cycles with arbitrary inputs -> tick_o, busy_o, done_o = 0 and tick_count_o = 0 after the first edge.
- Run: mode_i = run from cycle 0 for 35 cycles, then halt -> tick_o high at cycles 10, 20, 30 only; tick_count_o = 3; busy_o low after halt is sampled.
- Step: mode_i = step, start_i at cycle 0 -> single tick at cycle 10; done_o at cycle 11; busy_o high cycles 1–10.
- Burst:
  - burst_len_i = 3, start_i at cycle 0 -> ticks at 10, 20, 30; done_o at 31.
  - burst_len_i = 0 -> done_o at cycle 1, no tick, busy_o stays 0.
  - A second start_i at cycle 5 is ignored.
- Abort and reset mid-operation:
  - Burst of 5, mode_i = halt at cycle 15 -> exactly one tick (cycle 10); no done_o; busy_o low at cycle 16.
  - reset_i during RUN -> all outputs 0 at the next edge.
- DIV=1 (CORE_FREQ=CLK_FREQ=100): run mode -> tick_o high every cycle from cycle 1. Rebuild without CORE_TICK_COUNT_EN -> tick_count_o stays 0 throughout.
